// File: rtl/sgmii_pkg.sv
// Shared types and constants for the SGMII receive synchronisation block.
package sgmii_pkg;

    // Code-group synchronisation states (1000BASE-X clause 36).
    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        COMMA_DETECT_2,
        COMMA_DETECT_3,
        ACQUIRE_SYNC_1,
        ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4A
    } sync_state_t;

    // Ordered set building blocks seen on an idle link.
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D21_5 = 8'hB5;

    // True for every SYNC_ACQUIRED_* state.
    function automatic logic is_synced(input sync_state_t s);
        case (s)
            SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4,
            SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A: is_synced = 1'b1;
            default:                                             is_synced = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sgmii_rx_sync_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;

    // Clear first, then increment only while below all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/sgmii_rx_sync.sv
// Code-group synchronisation FSM, parity tracking, registered receive
// stream and statistics counters for the SGMII receive path.
module sgmii_rx_sync
    import sgmii_pkg::*;
#(
    parameter int GOOD_CGS = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk_125,
    input  logic             sgmii_reset_n,
    input  logic [7:0]       sgmii_rxd,
    input  logic             sgmii_rxisk,
    input  logic             sgmii_rxiscomma,
    input  logic             sgmii_rxdisperr,
    input  logic             sgmii_rxnotintable,
    input  logic             sgmii_elecidle,
    output logic             sgmii_encommaalign,
    output logic             sync_ok,
    output logic [7:0]       rx_data,
    output logic             rx_isk,
    output logic             rx_even,
    output logic             rx_valid,
    output logic [CNT_W-1:0] bad_cg_cnt,
    output logic [CNT_W-1:0] los_cnt,
    input  logic             cnt_clear
);

    localparam int            GCW       = $clog2(GOOD_CGS + 1);
    localparam logic [GCW-1:0] GOOD_LAST = GCW'(GOOD_CGS - 1);
    localparam logic [GCW-1:0] GOOD_ONE  = GCW'(1);

    sync_state_t    state;
    sync_state_t    next_state;
    logic [GCW-1:0] good_cnt;
    logic [GCW-1:0] next_good_cnt;
    logic           p;
    logic           accept_comma;

    logic invalid;
    logic comma;
    logic is_d;
    logic cgbad;
    logic cggood;

    assign invalid = sgmii_rxnotintable | sgmii_rxdisperr;
    assign comma   = sgmii_rxiscomma & ~invalid;
    assign is_d    = ~invalid & ~sgmii_rxisk;
    // A comma is only legal in an even code-group position.
    assign cgbad   = invalid | (comma & ~p);
    assign cggood  = ~cgbad;

    // Outputs decode only from the state register.
    assign sync_ok            = is_synced(state);
    assign sgmii_encommaalign = ~sync_ok;

    // State, good-code-group counter and parity registers.
    always_ff @(posedge clk_125 or negedge sgmii_reset_n) begin
        if (!sgmii_reset_n) begin
            state    <= LOSS_OF_SYNC;
            good_cnt <= '0;
            p        <= 1'b0;
        end else begin
            state    <= next_state;
            good_cnt <= next_good_cnt;
            // An accepted comma marks the even slot, so the next byte is odd.
            p        <= accept_comma ? 1'b0 : ~p;
        end
    end

    // Next-state logic; electrical idle overrides every other transition.
    always_comb begin
        next_state    = state;
        next_good_cnt = good_cnt;
        accept_comma  = 1'b0;
        if (sgmii_elecidle) begin
            next_state = LOSS_OF_SYNC;
        end else begin
            case (state)
                LOSS_OF_SYNC: begin
                    if (comma) begin
                        next_state   = COMMA_DETECT_1;
                        accept_comma = 1'b1;
                    end
                end
                COMMA_DETECT_1: next_state = is_d ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
                COMMA_DETECT_2: next_state = is_d ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
                COMMA_DETECT_3: next_state = is_d ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
                ACQUIRE_SYNC_1: begin
                    if (cgbad) begin
                        next_state = LOSS_OF_SYNC;
                    end else if (comma && p) begin
                        next_state   = COMMA_DETECT_2;
                        accept_comma = 1'b1;
                    end
                end
                ACQUIRE_SYNC_2: begin
                    if (cgbad) begin
                        next_state = LOSS_OF_SYNC;
                    end else if (comma && p) begin
                        next_state   = COMMA_DETECT_3;
                        accept_comma = 1'b1;
                    end
                end
                SYNC_ACQUIRED_1: begin
                    if (cgbad) begin
                        next_state    = SYNC_ACQUIRED_2;
                        next_good_cnt = '0;
                    end
                end
                SYNC_ACQUIRED_2: begin
                    next_state    = cggood ? SYNC_ACQUIRED_2A : SYNC_ACQUIRED_3;
                    next_good_cnt = cggood ? GOOD_ONE : '0;
                end
                SYNC_ACQUIRED_3: begin
                    next_state    = cggood ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4;
                    next_good_cnt = cggood ? GOOD_ONE : '0;
                end
                SYNC_ACQUIRED_4: begin
                    next_state    = cggood ? SYNC_ACQUIRED_4A : LOSS_OF_SYNC;
                    next_good_cnt = cggood ? GOOD_ONE : '0;
                end
                SYNC_ACQUIRED_2A: begin
                    if (cgbad) begin
                        next_state    = SYNC_ACQUIRED_3;
                        next_good_cnt = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        next_state    = SYNC_ACQUIRED_1;
                        next_good_cnt = '0;
                    end else begin
                        next_good_cnt = good_cnt + GOOD_ONE;
                    end
                end
                SYNC_ACQUIRED_3A: begin
                    if (cgbad) begin
                        next_state    = SYNC_ACQUIRED_4;
                        next_good_cnt = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        next_state    = SYNC_ACQUIRED_2;
                        next_good_cnt = '0;
                    end else begin
                        next_good_cnt = good_cnt + GOOD_ONE;
                    end
                end
                SYNC_ACQUIRED_4A: begin
                    if (cgbad) begin
                        next_state    = LOSS_OF_SYNC;
                        next_good_cnt = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        next_state    = SYNC_ACQUIRED_3;
                        next_good_cnt = '0;
                    end else begin
                        next_good_cnt = good_cnt + GOOD_ONE;
                    end
                end
                default: next_state = LOSS_OF_SYNC;
            endcase
        end
    end

    // One-cycle registered receive stream, qualified by prior sync status.
    always_ff @(posedge clk_125 or negedge sgmii_reset_n) begin
        if (!sgmii_reset_n) begin
            rx_data  <= 8'h00;
            rx_isk   <= 1'b0;
            rx_even  <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_data  <= sgmii_rxd;
            rx_isk   <= sgmii_rxisk;
            rx_even  <= p;
            rx_valid <= sync_ok & cggood;
        end
    end

    logic bad_inc;
    logic los_inc;

    assign bad_inc = sync_ok & cgbad;
    assign los_inc = sync_ok & (next_state == LOSS_OF_SYNC);

    sat_counter #(.WIDTH(CNT_W)) u_bad_cnt (
        .clk   (clk_125),
        .rst_n (sgmii_reset_n),
        .inc   (bad_inc),
        .clr   (cnt_clear),
        .count (bad_cg_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_los_cnt (
        .clk   (clk_125),
        .rst_n (sgmii_reset_n),
        .inc   (los_inc),
        .clr   (cnt_clear),
        .count (los_cnt)
    );

endmodule
